// File: rtl/vp_pkg.sv
// Shared types and widths for the writeback path: register-file geometry and the
// pending-write record carried by the writeback FIFO.
package vp_pkg;

  localparam int VREG_ADDR_W = 3;
  localparam int VDATA_W     = 64;
  localparam int EDATA_W     = 8;
  localparam int NUM_REGS    = 8;

  typedef struct packed {
    logic                   is_vec;
    logic [VREG_ADDR_W-1:0] dir;
    logic [VDATA_W-1:0]     vdata;
    logic [EDATA_W-1:0]     edata;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order pending-write FIFO for the writeback unit. Head is read combinationally;
// push is ignored when full and pop when empty.
module wb_fifo
  import vp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  wb_entry_t                wdata_i,
  output wb_entry_t                rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Explicit wrap keeps the pointers correct even if DEPTH is not a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: queues execute results in order and retires one per cycle to the
// vector or scalar bank. Macro WB_SCOREBOARD_EN enables the busy_v/busy_e pending flags.
module writeback_unit
  import vp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_is_vec,
  input  logic [VREG_ADDR_W-1:0] in_dir,
  input  logic [VDATA_W-1:0]     in_vdata,
  input  logic [EDATA_W-1:0]     in_edata,
  output logic [VREG_ADDR_W-1:0] dir_esc,
  output logic [VDATA_W-1:0]     data,
  output logic                   signal_esc,
  output logic [VREG_ADDR_W-1:0] dir_escE,
  output logic [EDATA_W-1:0]     dataE,
  output logic                   signal_escE,
  output logic [NUM_REGS-1:0]    busy_v,
  output logic [NUM_REGS-1:0]    busy_e,
  output logic                   idle
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshake: a result transfers on a rising edge with in_valid && in_ready.
  // in_ready depends only on FIFO occupancy (and on having left reset), never on
  // in_valid or on the pop happening in the same cycle.
  logic             rdy_en_q;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        in_entry;
  wb_entry_t        head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  assign in_ready = rdy_en_q && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = !fifo_empty;
  assign idle     = (fifo_count == '0);

  assign in_entry.is_vec = in_is_vec;
  assign in_entry.dir    = in_dir;
  assign in_entry.vdata  = in_vdata;
  assign in_entry.edata  = in_edata;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (in_entry),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Exactly one bank sees the head; the other port stays fully quiet.
  always_comb begin
    signal_esc  = 1'b0;
    dir_esc     = '0;
    data        = '0;
    signal_escE = 1'b0;
    dir_escE    = '0;
    dataE       = '0;
    if (!fifo_empty) begin
      if (head.is_vec) begin
        signal_esc = 1'b1;
        dir_esc    = head.dir;
        data       = head.vdata;
      end else begin
        signal_escE = 1'b1;
        dir_escE    = head.dir;
        dataE       = head.edata;
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  // Per-register pending counts so repeated writes to one register keep it busy
  // until the last of them retires.
  logic [CNT_W-1:0] pend_v_q [NUM_REGS];
  logic [CNT_W-1:0] pend_v_d [NUM_REGS];
  logic [CNT_W-1:0] pend_e_q [NUM_REGS];
  logic [CNT_W-1:0] pend_e_d [NUM_REGS];

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      pend_v_d[i] = pend_v_q[i];
      pend_e_d[i] = pend_e_q[i];
      case ({push && in_is_vec && (in_dir == VREG_ADDR_W'(i)),
             pop && head.is_vec && (head.dir == VREG_ADDR_W'(i))})
        2'b10:   pend_v_d[i] = pend_v_q[i] + CNT_W'(1);
        2'b01:   pend_v_d[i] = pend_v_q[i] - CNT_W'(1);
        default: pend_v_d[i] = pend_v_q[i];
      endcase
      case ({push && !in_is_vec && (in_dir == VREG_ADDR_W'(i)),
             pop && !head.is_vec && (head.dir == VREG_ADDR_W'(i))})
        2'b10:   pend_e_d[i] = pend_e_q[i] + CNT_W'(1);
        2'b01:   pend_e_d[i] = pend_e_q[i] - CNT_W'(1);
        default: pend_e_d[i] = pend_e_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_v_q[i] <= '0;
        pend_e_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        pend_v_q[i] <= pend_v_d[i];
        pend_e_q[i] <= pend_e_d[i];
      end
    end
  end

  always_comb begin
    busy_v = '0;
    busy_e = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_v[i] = (pend_v_q[i] != '0);
      busy_e[i] = (pend_e_q[i] != '0);
    end
  end
`else
  assign busy_v = '0;
  assign busy_e = '0;
`endif

endmodule
